// File: rtl/traffic_inject_ctrl.sv
// rtl/traffic_inject_ctrl.sv - sequencer for one traffic buffer: Init, Fill, PreDeque, credit-gated Dequeue
module traffic_inject_ctrl #(
  parameter int DATA_W    = 32,
  parameter int OP_W      = 3,
  parameter int VC_W      = 1,
  parameter int NF_LSB    = 0,
  parameter int CRED_W    = 4,
  parameter int CRED_INIT = 4,
  parameter logic [OP_W-1:0] OP_NOP     = OP_W'(0),
  parameter logic [OP_W-1:0] OP_INIT    = OP_W'(1),
  parameter logic [OP_W-1:0] OP_FILL    = OP_W'(2),
  parameter logic [OP_W-1:0] OP_PREDEQ  = OP_W'(3),
  parameter logic [OP_W-1:0] OP_DEQUEUE = OP_W'(4)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [9:0]            total_pkts,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [DATA_W-1:0]     cfg_data,
  output logic [OP_W-1:0]       tr_op,
  output logic [DATA_W-1:0]     tr_data,
  input  logic [VC_W-1:0]       tr_vc,
  input  logic [(2**VC_W)-1:0]  credit_ret,
  output logic                  flit_send,
  output logic                  busy,
  output logic                  finished,
  output logic                  cfg_err
);

  localparam int NUM_VC = 2 ** VC_W;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CRED_INIT);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_FILL, S_PRIME, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          npkt_q, npkt_d;
  logic [9:0]          fill_cnt_q, fill_cnt_d;
  logic [19:0]         flit_total_q, flit_total_d;
  logic [19:0]         sent_cnt_q, sent_cnt_d;
  logic [CRED_W-1:0]   credit_q [NUM_VC];
  logic [CRED_W-1:0]   credit_d [NUM_VC];
  logic [OP_W-1:0]     tr_op_q, tr_op_d;
  logic [DATA_W-1:0]   tr_data_q, tr_data_d;
  logic                flit_send_q, flit_send_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;
  logic                cfg_err_q, cfg_err_d;
  logic [NUM_VC-1:0]   consume;
  logic [9:0]          desc_nf;

  assign desc_nf   = cfg_data[NF_LSB +: 10];
  assign cfg_ready = (state_q == S_FILL);
  assign tr_op     = tr_op_q;
  assign tr_data   = tr_data_q;
  assign flit_send = flit_send_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign cfg_err   = cfg_err_q;

  always_comb begin
    state_d      = state_q;
    npkt_d       = npkt_q;
    fill_cnt_d   = fill_cnt_q;
    flit_total_d = flit_total_q;
    sent_cnt_d   = sent_cnt_q;
    tr_op_d      = OP_NOP;
    tr_data_d    = tr_data_q;
    flit_send_d  = 1'b0;
    cfg_err_d    = cfg_err_q;
    consume      = '0;
    busy_d       = (state_q != S_IDLE) && (state_q != S_DONE);
    finished_d   = (state_q == S_DONE);

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (total_pkts == 10'd0) begin
            state_d = S_DONE;
          end else begin
            npkt_d       = total_pkts;
            fill_cnt_d   = 10'd0;
            flit_total_d = 20'd0;
            sent_cnt_d   = 20'd0;
            cfg_err_d    = 1'b0;
            state_d      = S_INIT;
          end
        end
      end
      S_INIT: begin
        tr_op_d   = OP_INIT;
        tr_data_d = DATA_W'(npkt_q - 10'd1);
        state_d   = S_FILL;
      end
      S_FILL: begin
        if (cfg_valid) begin
          tr_op_d      = OP_FILL;
          tr_data_d    = cfg_data;
          fill_cnt_d   = fill_cnt_q + 10'd1;
          flit_total_d = flit_total_q + 20'(desc_nf);
          if (desc_nf == 10'd0) cfg_err_d = 1'b1;
          if (fill_cnt_q + 10'd1 == npkt_q) state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        // An all-empty run has nothing to prime or dequeue.
        if (flit_total_q == 20'd0) begin
          state_d = S_DONE;
        end else begin
          tr_op_d = OP_PREDEQ;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (credit_q[tr_vc] != '0) begin
          flit_send_d    = 1'b1;
          consume[tr_vc] = 1'b1;
          sent_cnt_d     = sent_cnt_q + 20'd1;
          if (sent_cnt_q + 20'd1 == flit_total_q) begin
            state_d = S_DONE;
          end else begin
            tr_op_d = OP_DEQUEUE;
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A return on the same VC as a consume cancels out; returns saturate at CRED_INIT.
  always_comb begin
    for (int v = 0; v < NUM_VC; v++) begin
      credit_d[v] = credit_q[v];
      if (consume[v] && !credit_ret[v]) begin
        credit_d[v] = credit_q[v] - CRED_W'(1);
      end else if (!consume[v] && credit_ret[v] && (credit_q[v] < CRED_MAX)) begin
        credit_d[v] = credit_q[v] + CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      npkt_q       <= 10'd0;
      fill_cnt_q   <= 10'd0;
      flit_total_q <= 20'd0;
      sent_cnt_q   <= 20'd0;
      tr_op_q      <= OP_NOP;
      tr_data_q    <= '0;
      flit_send_q  <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= CRED_MAX;
    end else begin
      state_q      <= state_d;
      npkt_q       <= npkt_d;
      fill_cnt_q   <= fill_cnt_d;
      flit_total_q <= flit_total_d;
      sent_cnt_q   <= sent_cnt_d;
      tr_op_q      <= tr_op_d;
      tr_data_q    <= tr_data_d;
      flit_send_q  <= flit_send_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      cfg_err_q    <= cfg_err_d;
      for (int v = 0; v < NUM_VC; v++) credit_q[v] <= credit_d[v];
    end
  end

endmodule

// File: tb/tb_traffic_inject_ctrl.sv
// tb/tb_traffic_inject_ctrl.sv - self-checking bench for traffic_inject_ctrl
module tb_traffic_inject_ctrl;

  localparam logic [2:0] OP_NOP = 3'd0, OP_INIT = 3'd1, OP_FILL = 3'd2,
                         OP_PREDEQ = 3'd3, OP_DEQ = 3'd4;
  localparam int CI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  total_pkts = '0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_data = '0;
  logic [2:0]  tr_op;
  logic [31:0] tr_data;
  logic [0:0]  tr_vc;
  logic [1:0]  credit_ret = '0;
  logic        flit_send, busy, finished, cfg_err;

  traffic_inject_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .total_pkts(total_pkts),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
    .tr_op(tr_op), .tr_data(tr_data), .tr_vc(tr_vc), .credit_ret(credit_ret),
    .flit_send(flit_send), .busy(busy), .finished(finished), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Buffer model: VC of every flit of the current run, in dequeue order.
  bit          fvc [0:511];
  int          fidx = 0;
  assign tr_vc = fvc[fidx];

  // Observation log and credit reference, updated once per cycle.
  int          cyc = 0;
  logic [2:0]  opq_op [$];
  logic [31:0] opq_data [$];
  int          opq_cyc [$];
  int          send_cyc [$];
  int          send_cred [$];
  int          mcred [2] = '{CI, CI};
  logic [1:0]  prev_ret = '0;
  logic        prev_fin = 1'b0;
  int          fin_cyc = -1;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      mcred = '{CI, CI};
      prev_ret = '0;
      prev_fin = 1'b0;
    end else begin
      if (tr_op != OP_NOP) begin
        opq_op.push_back(tr_op);
        opq_data.push_back(tr_data);
        opq_cyc.push_back(cyc);
      end
      if (tr_op == OP_INIT) fidx = 0;
      for (int v = 0; v < 2; v++) begin
        int s;
        s = (flit_send && (int'(fvc[fidx]) == v)) ? 1 : 0;
        if (s == 1) send_cred.push_back(mcred[v]);
        mcred[v] = mcred[v] - s + int'(prev_ret[v]);
        if (mcred[v] > CI) mcred[v] = CI;
      end
      if (flit_send) begin
        send_cyc.push_back(cyc);
        fidx++;
      end
      prev_ret = credit_ret;
      if (finished && !prev_fin) fin_cyc = cyc;
      prev_fin = finished;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; credit_ret = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  function automatic logic [1:0] rand_ret(input int p);
    logic [1:0] r;
    r[0] = ($urandom_range(99) < p);
    r[1] = ($urandom_range(99) < p);
    return r;
  endfunction

  int          run_n;
  int          run_nf [4];
  bit          run_vc [4];
  logic [31:0] run_desc [4];
  int          run_total;
  bit          run_err;
  int          last_base_op, last_base_snd;

  task automatic prep_run();
    int t;
    t = 0;
    run_err = 1'b0;
    for (int k = 0; k < run_n; k++) begin
      run_desc[k] = ($urandom() & 32'hFFFF_F800) | (32'(run_vc[k]) << 10) | 32'(run_nf[k]);
      if (run_nf[k] == 0) run_err = 1'b1;
      for (int f = 0; f < run_nf[k]; f++) begin
        fvc[t] = run_vc[k];
        t++;
      end
    end
    run_total = t;
  endtask

  // Expected op stream: Init(N-1), N Fills, PreDeque when any flits, then total-1 Dequeues.
  task automatic check_ops(input int base, input string tag);
    int ne, got;
    ne  = 1 + run_n + run_total;
    got = opq_op.size() - base;
    chk($sformatf("%s op_count", tag), got, ne);
    if (got == ne) begin
      for (int i = 0; i < ne; i++) begin
        logic [2:0] eop;
        if (i == 0) eop = OP_INIT;
        else if (i <= run_n) eop = OP_FILL;
        else if (i == run_n + 1) eop = OP_PREDEQ;
        else eop = OP_DEQ;
        chk($sformatf("%s op[%0d]", tag, i), opq_op[base+i], eop);
        if (i == 0) chk($sformatf("%s init_data", tag), opq_data[base], run_n - 1);
        else if (i <= run_n) chk($sformatf("%s fill_data[%0d]", tag, i), opq_data[base+i], run_desc[i-1]);
      end
    end
  endtask

  task automatic check_sends(input int base, input string tag);
    int bad, gapbad;
    bad = 0; gapbad = 0;
    chk($sformatf("%s sends", tag), send_cyc.size() - base, run_total);
    for (int i = base; i < send_cyc.size(); i++) begin
      if (send_cred[i] <= 0) bad++;
      if (i > base && send_cyc[i] - send_cyc[i-1] < 2) gapbad++;
    end
    chk($sformatf("%s send_without_credit", tag), bad, 0);
    chk($sformatf("%s send_spacing", tag), gapbad, 0);
  endtask

  // vprob < 0 selects an alternating cfg_valid pattern.
  task automatic do_run(input string tag, input int vprob, input int rprob);
    int k, guard;
    bit acc, tog;
    prep_run();
    last_base_op = opq_op.size();
    last_base_snd = send_cyc.size();
    total_pkts = 10'(run_n); start = 1'b1;
    step();
    start = 1'b0;
    k = 0; guard = 0; tog = 1'b1;
    while (k < run_n && guard < 2000) begin
      cfg_valid = (vprob < 0) ? tog : ($urandom_range(99) < vprob);
      tog = ~tog;
      cfg_data = run_desc[k];
      credit_ret = rand_ret(rprob);
      acc = cfg_valid && cfg_ready;
      step();
      if (acc) k++;
      guard++;
    end
    cfg_valid = 1'b0;
    while (!finished && guard < 4000) begin
      credit_ret = rand_ret(rprob);
      step();
      guard++;
    end
    credit_ret = '0;
    chk($sformatf("%s finished", tag), finished, 1);
    step(); step();
    check_ops(last_base_op, tag);
    check_sends(last_base_snd, tag);
    chk($sformatf("%s cfg_err", tag), cfg_err, run_err);
  endtask

  typedef struct packed {
    int             n;
    logic [3:0][7:0] nf;
    logic [3:0]     vc;
    int             exp_sends;
    logic           exp_err;
  } vec_t;

  function automatic vec_t mk(input int n, input int a, input int b, input int c, input int d,
                              input logic [3:0] vc, input int es, input logic ee);
    vec_t r;
    r.n = n; r.nf[0] = 8'(a); r.nf[1] = 8'(b); r.nf[2] = 8'(c); r.nf[3] = 8'(d);
    r.vc = vc; r.exp_sends = es; r.exp_err = ee;
    return r;
  endfunction

  vec_t tbl [6];

  initial begin
    int base, c0, g;
    bit acc;

    tbl[0] = mk(1, 1, 0, 0, 0, 4'b0000, 1, 1'b0);
    tbl[1] = mk(2, 2, 3, 0, 0, 4'b0010, 5, 1'b0);
    tbl[2] = mk(3, 0, 2, 1, 0, 4'b0100, 3, 1'b1);
    tbl[3] = mk(4, 1, 1, 1, 1, 4'b1010, 4, 1'b0);
    tbl[4] = mk(2, 4, 4, 0, 0, 4'b0010, 8, 1'b0);
    tbl[5] = mk(4, 5, 0, 3, 2, 4'b0101, 10, 1'b1);

    // Reset state
    step(); step();
    chk("rst tr_op", tr_op, OP_NOP);
    chk("rst tr_data", tr_data, 0);
    chk("rst cfg_ready", cfg_ready, 0);
    chk("rst flit_send", flit_send, 0);
    chk("rst busy", busy, 0);
    chk("rst finished", finished, 0);
    chk("rst cfg_err", cfg_err, 0);
    rst = 1'b0;
    step();

    // N=2, 3 flits vc0 + 1 flit vc1, no credit returns: exact cadence
    run_n = 2; run_nf[0] = 3; run_nf[1] = 1; run_vc[0] = 0; run_vc[1] = 1;
    do_run("n2", 100, 0);
    for (int i = last_base_snd + 1; i < send_cyc.size(); i++)
      chk("n2 send_gap", send_cyc[i] - send_cyc[i-1], 2);
    if (send_cyc.size() > 0)
      chk("n2 finished_after_last_send", fin_cyc, send_cyc[send_cyc.size()-1] + 1);

    // Credit stall: 6 flits on vc0 with only 4 credits
    do_reset();
    run_n = 1; run_nf[0] = 6; run_vc[0] = 0;
    prep_run();
    last_base_op = opq_op.size(); last_base_snd = send_cyc.size();
    total_pkts = 10'd1; start = 1'b1; step(); start = 1'b0;
    g = 0;
    cfg_data = run_desc[0];
    acc = 1'b0;
    while (!acc && g < 50) begin
      cfg_valid = 1'b1;
      acc = cfg_ready;
      step();
      g++;
    end
    cfg_valid = 1'b0;
    for (int i = 0; i < 40; i++) step();
    chk("stall sends_before_ret", send_cyc.size() - last_base_snd, 4);
    chk("stall not_finished", finished, 0);
    c0 = cyc;
    credit_ret = 2'b01; step(); credit_ret = 2'b00;
    step(); step(); step();
    chk("stall fifth_send", send_cyc.size() - last_base_snd, 5);
    if (send_cyc.size() > 0) chk("stall fifth_send_cycle", send_cyc[send_cyc.size()-1], c0 + 3);
    credit_ret = 2'b01; step(); credit_ret = 2'b00;
    g = 0;
    while (!finished && g < 50) begin step(); g++; end
    chk("stall finished", finished, 1);
    step(); step();
    check_ops(last_base_op, "stall");
    check_sends(last_base_snd, "stall");

    // Reset mid-FILL after 2 of 4 descriptors, then rerun (credits back to 4)
    run_n = 4; for (int k = 0; k < 4; k++) begin run_nf[k] = 1; run_vc[k] = 0; end
    prep_run();
    total_pkts = 10'd4; start = 1'b1; step(); start = 1'b0;
    g = 0; c0 = 0;
    while (c0 < 2 && g < 50) begin
      cfg_valid = 1'b1; cfg_data = run_desc[c0];
      acc = cfg_ready;
      step();
      if (acc) c0++;
      g++;
    end
    cfg_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk("midrst tr_op", tr_op, OP_NOP);
    chk("midrst cfg_ready", cfg_ready, 0);
    chk("midrst busy", busy, 0);
    step();
    rst = 1'b0; cfg_valid = 1'b0;
    base = opq_op.size();
    for (int i = 0; i < 6; i++) step();
    chk("midrst no_ops_after_reset", opq_op.size() - base, 0);
    do_run("rerun", 100, 0);

    // Simultaneous consume and return on vc0 while its credit is 1
    do_reset();
    run_n = 1; run_nf[0] = 3; run_vc[0] = 0;
    do_run("drain", 100, 0);
    run_nf[0] = 2;
    prep_run();
    last_base_op = opq_op.size(); last_base_snd = send_cyc.size();
    total_pkts = 10'd1; start = 1'b1; step(); start = 1'b0;
    cfg_valid = 1'b1; cfg_data = run_desc[0];
    step(); step();
    cfg_valid = 1'b0;
    step(); step();
    credit_ret = 2'b01; step(); credit_ret = 2'b00;
    chk("simul first_send", flit_send, 1);
    g = 0;
    while (!finished && g < 20) begin step(); g++; end
    chk("simul finished", finished, 1);
    step(); step();
    check_sends(last_base_snd, "simul");
    if (send_cyc.size() - last_base_snd == 2)
      chk("simul no_stall_gap", send_cyc[send_cyc.size()-1] - send_cyc[send_cyc.size()-2], 2);

    // Backpressured fill: cfg_valid alternates, N=3
    do_reset();
    run_n = 3;
    for (int k = 0; k < 3; k++) begin run_nf[k] = $urandom_range(1, 2); run_vc[k] = $urandom_range(0, 1); end
    do_run("bp", -1, 50);
    if (opq_op.size() - last_base_op >= 4)
      for (int i = 2; i <= 3; i++)
        chk("bp fill_gap", opq_cyc[last_base_op+i] - opq_cyc[last_base_op+i-1], 2);

    // N=0 start, then a single zero-flit descriptor
    do_reset();
    base = opq_op.size();
    total_pkts = 10'd0; start = 1'b1; step(); start = 1'b0;
    step();
    chk("n0 finished", finished, 1);
    chk("n0 busy", busy, 0);
    step(); step();
    chk("n0 no_ops", opq_op.size() - base, 0);
    run_n = 1; run_nf[0] = 0; run_vc[0] = 0;
    do_run("zero_flit", 100, 0);

    // Table of runs
    for (int i = 0; i < 6; i++) begin
      run_n = tbl[i].n;
      for (int k = 0; k < 4; k++) begin run_nf[k] = int'(tbl[i].nf[k]); run_vc[k] = tbl[i].vc[k]; end
      do_run($sformatf("tbl%0d", i), 70, 40);
      chk($sformatf("tbl%0d exp_sends", i), send_cyc.size() - last_base_snd, tbl[i].exp_sends);
      chk($sformatf("tbl%0d exp_err", i), cfg_err, tbl[i].exp_err);
    end

    // Randomized runs; credits carry over between runs
    for (int r = 0; r < 12; r++) begin
      run_n = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) begin run_nf[k] = $urandom_range(0, 6); run_vc[k] = $urandom_range(0, 1); end
      do_run($sformatf("rnd%0d", r), 60, 40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
